// File: rtl/ics_pkg.sv
// Shared types and constants for the ics_tap JTAG TAP controller.
package ics_pkg;

  localparam int IR_W_DEF = 4;
  localparam int DR_W_DEF = 8;
  localparam int ID_W     = 32;

  typedef enum logic [3:0] {
    ST_TLR      = 4'hF,
    ST_RTI      = 4'hC,
    ST_SEL_DR   = 4'h7,
    ST_CAP_DR   = 4'h6,
    ST_SHIFT_DR = 4'h2,
    ST_EXIT1_DR = 4'h1,
    ST_PAUSE_DR = 4'h3,
    ST_EXIT2_DR = 4'h0,
    ST_UPD_DR   = 4'h5,
    ST_SEL_IR   = 4'h4,
    ST_CAP_IR   = 4'hE,
    ST_SHIFT_IR = 4'hA,
    ST_EXIT1_IR = 4'h9,
    ST_PAUSE_IR = 4'hB,
    ST_EXIT2_IR = 4'h8,
    ST_UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [3:0] INS_IDCODE = 4'b0001;
  localparam logic [3:0] INS_USER   = 4'b0010;
  localparam logic [3:0] INS_BYPASS = 4'b1111;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/ics_tap_fsm.sv
// TAP state register and TMS-driven next-state logic (16-state 1149.1 FSM).
module ics_tap_fsm
  import ics_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_TLR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/ics_tap.sv
// JTAG TAP top: IR, BYPASS/IDCODE/USER data registers and the TDO mux.
module ics_tap
  import ics_pkg::*;
#(
  parameter int          IR_W       = IR_W_DEF,
  parameter int          DR_W       = DR_W_DEF,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
  input  logic            TCK,
  input  logic            TRST,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic [3:0]      STATE,
  output logic [IR_W-1:0] IR,
  output logic [DR_W-1:0] DR
);

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(INS_IDCODE);
  localparam logic [IR_W-1:0] IR_USER   = IR_W'(INS_USER);

  tap_state_e state;
  dr_sel_e    sel;

  logic [IR_W-1:0] ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [DR_W-1:0] dr_q, dr_d, dr_shift_q, dr_shift_d;
  logic [ID_W-1:0] id_shift_q, id_shift_d;
  logic            bypass_q, bypass_d;

  ics_tap_fsm u_fsm (
    .clk     (TCK),
    .rst     (TRST),
    .tms     (TMS),
    .state_o (state)
  );

  // Unlisted instruction codes fall back to BYPASS.
  always_comb begin
    if (ir_q == IR_IDCODE)    sel = SEL_IDCODE;
    else if (ir_q == IR_USER) sel = SEL_USER;
    else                      sel = SEL_BYPASS;
  end

  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    dr_d       = dr_q;
    dr_shift_d = dr_shift_q;
    id_shift_d = id_shift_q;
    bypass_d   = bypass_q;
    unique case (state)
      ST_TLR:      ir_d       = IR_IDCODE;
      ST_CAP_IR:   ir_shift_d = IR_IDCODE;
      ST_SHIFT_IR: ir_shift_d = {TDI, ir_shift_q[IR_W-1:1]};
      ST_UPD_IR:   ir_d       = ir_shift_q;
      ST_CAP_DR: begin
        unique case (sel)
          SEL_IDCODE: id_shift_d = IDCODE_VAL;
          SEL_USER:   dr_shift_d = dr_q;
          default:    bypass_d   = 1'b0;
        endcase
      end
      ST_SHIFT_DR: begin
        unique case (sel)
          SEL_IDCODE: id_shift_d = {TDI, id_shift_q[ID_W-1:1]};
          SEL_USER:   dr_shift_d = {TDI, dr_shift_q[DR_W-1:1]};
          default:    bypass_d   = TDI;
        endcase
      end
      ST_UPD_DR:   if (sel == SEL_USER) dr_d = dr_shift_q;
      default: ;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
      dr_q       <= '0;
      dr_shift_q <= '0;
      id_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      dr_q       <= dr_d;
      dr_shift_q <= dr_shift_d;
      id_shift_q <= id_shift_d;
      bypass_q   <= bypass_d;
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (state == ST_SHIFT_IR) begin
      TDO = ir_shift_q[0];
    end else if (state == ST_SHIFT_DR) begin
      unique case (sel)
        SEL_IDCODE: TDO = id_shift_q[0];
        SEL_USER:   TDO = dr_shift_q[0];
        default:    TDO = bypass_q;
      endcase
    end
  end

  assign STATE = state;
  assign IR    = ir_q;
  assign DR    = dr_q;

endmodule

// File: tb/tb_ics_tap.sv
// Bench for ics_tap: edge-level reference model feeds an expected queue, a negedge monitor compares.
module tb_ics_tap;

  localparam int          IR_W = 4;
  localparam int          DR_W = 8;
  localparam logic [31:0] IDV  = 32'h1234_5001;
  localparam int          EW   = 4 + IR_W + DR_W + 1;

  logic            TCK = 1'b0;
  logic            TRST = 1'b1, TMS = 1'b1, TDI = 1'b0;
  logic            TDO;
  logic [3:0]      STATE;
  logic [IR_W-1:0] IR;
  logic [DR_W-1:0] DR;

  ics_tap #(.IR_W(IR_W), .DR_W(DR_W), .IDCODE_VAL(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .STATE(STATE), .IR(IR), .DR(DR)
  );

  always #5 TCK = ~TCK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: state held as its hex code, registers as plain integers.
  logic [3:0]      m_state = 4'hF;
  logic [IR_W-1:0] m_ir = 1, m_irs = 0;
  logic [DR_W-1:0] m_dr = 0, m_drs = 0;
  logic [31:0]     m_id = 0;
  logic            m_byp = 0;

  function automatic logic [3:0] next_code(logic [3:0] s, bit tms);
    case (s)
      4'hF: return tms ? 4'hF : 4'hC;
      4'hC: return tms ? 4'h7 : 4'hC;
      4'h7: return tms ? 4'h4 : 4'h6;
      4'h4: return tms ? 4'hF : 4'hE;
      4'h6: return tms ? 4'h1 : 4'h2;
      4'h2: return tms ? 4'h1 : 4'h2;
      4'h1: return tms ? 4'h5 : 4'h3;
      4'h3: return tms ? 4'h0 : 4'h3;
      4'h0: return tms ? 4'h5 : 4'h2;
      4'h5: return tms ? 4'h7 : 4'hC;
      4'hE: return tms ? 4'h9 : 4'hA;
      4'hA: return tms ? 4'h9 : 4'hA;
      4'h9: return tms ? 4'hD : 4'hB;
      4'hB: return tms ? 4'h8 : 4'hB;
      4'h8: return tms ? 4'hD : 4'hA;
      default: return tms ? 4'h7 : 4'hC;
    endcase
  endfunction

  // 1 = IDCODE, 2 = USER, 0 = BYPASS
  function automatic int m_sel();
    if (m_ir == 1) return 1;
    if (m_ir == 2) return 2;
    return 0;
  endfunction

  function automatic bit m_tdo();
    if (m_state == 4'hA) return m_irs[0];
    if (m_state == 4'h2) begin
      case (m_sel())
        1:       return m_id[0];
        2:       return m_drs[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input bit tms, input bit tdi, input bit trst);
    if (trst) begin
      m_state = 4'hF; m_ir = 1; m_irs = 0; m_dr = 0; m_drs = 0; m_id = 0; m_byp = 0;
      return;
    end
    case (m_state)
      4'hF: m_ir = 1;
      4'hE: m_irs = 1;
      4'hA: m_irs = (m_irs >> 1) | (IR_W'(tdi) << (IR_W - 1));
      4'hD: m_ir = m_irs;
      4'h6: case (m_sel())
              1:       m_id = IDV;
              2:       m_drs = m_dr;
              default: m_byp = 1'b0;
            endcase
      4'h2: case (m_sel())
              1:       m_id = (m_id >> 1) | (32'(tdi) << 31);
              2:       m_drs = (m_drs >> 1) | (DR_W'(tdi) << (DR_W - 1));
              default: m_byp = tdi;
            endcase
      4'h5: if (m_sel() == 2) m_dr = m_drs;
      default: ;
    endcase
    m_state = next_code(m_state, tms);
  endtask

  task automatic step(input bit tms, input bit tdi, input bit trst);
    TMS = tms; TDI = tdi; TRST = trst;
    @(posedge TCK); #1;
    model_edge(tms, tdi, trst);
    exp_q.push_back({m_state, m_ir, m_dr, m_tdo()});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge TCK) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({STATE, IR, DR, TDO} !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got state=%h ir=%h dr=%h tdo=%b expected state=%h ir=%h dr=%h tdo=%b",
                 $time, STATE, IR, DR, TDO, e[EW-1 -: 4], e[EW-5 -: IR_W], e[DR_W:1], e[0]);
      end
    end
  end

  // Shifts n bits LSB-first (TMS=1 on the last) and returns what TDO presented before each edge.
  task automatic shift_bits(input logic [63:0] d, input int n, output logic [63:0] q);
    q = '0;
    for (int i = 0; i < n; i++) begin
      q[i] = TDO;
      step(i == n - 1, d[i], 1'b0);
    end
  endtask

  task automatic enter_ir_shift();
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
  endtask

  task automatic enter_dr_shift();
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
  endtask

  task automatic update_to_rti();
    step(1, 0, 0); step(0, 0, 0);
  endtask

  task automatic load_ir(input logic [IR_W-1:0] v);
    logic [63:0] q;
    enter_ir_shift();
    shift_bits(64'(v), IR_W, q);
    update_to_rti();
  endtask

  task automatic pause_resume(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q;
    logic [3:0]  walk_codes [12];
    logic [11:0] walk_tms;
    logic [31:0] rnd;
    logic [DR_W-1:0] dr_keep;

    // Reset and TLR lock
    step(1, 0, 1);
    check("rst_state", 32'(STATE), 32'hF);
    check("rst_ir", 32'(IR), 32'h1);
    check("rst_dr", 32'(DR), 32'h0);
    check("rst_tdo", 32'(TDO), 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    check("tlr_hold", 32'(STATE), 32'hF);
    step(0, 0, 0);
    enter_dr_shift();
    check("in_shift_dr", 32'(STATE), 32'h2);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    check("tms5_to_tlr", 32'(STATE), 32'hF);

    // Full state walk
    walk_tms = 12'b0110_1010_0110;
    walk_codes = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hA, 4'h9, 4'hD, 4'hC};
    for (int i = 0; i < 12; i++) begin
      step(walk_tms[i], 0, 0);
      check($sformatf("walk_%0d", i), 32'(STATE), 32'(walk_codes[i]));
    end

    // IR load with pause
    enter_ir_shift();
    shift_bits(64'b0010, 4, q);
    check("ir_capture_tdo", q[31:0], 32'h1);
    pause_resume(6);
    shift_bits(64'b0010, 4, q);
    update_to_rti();
    check("ir_user", 32'(IR), 32'h2);

    // User DR write with pause, then readback
    enter_dr_shift();
    shift_bits(64'h81, 8, q);
    pause_resume(4);
    shift_bits(64'h55, 8, q);
    update_to_rti();
    check("dr_write", 32'(DR), 32'h55);
    enter_dr_shift();
    shift_bits(64'h55, 8, q);
    update_to_rti();
    check("dr_readback", q[31:0], 32'h55);

    // IDCODE readout
    step(1, 0, 1);
    step(0, 0, 0);
    enter_dr_shift();
    rnd = $urandom;
    shift_bits(64'(rnd), 32, q);
    update_to_rti();
    check("idcode", q[31:0], IDV);

    // BYPASS: one-cycle delay, DR untouched
    dr_keep = m_dr;
    load_ir(4'b1111);
    enter_dr_shift();
    shift_bits(64'b011, 3, q);
    update_to_rti();
    check("bypass_tdo", q[31:0], 32'b110);
    check("bypass_dr", 32'(DR), 32'(dr_keep));
    load_ir(4'b0111);
    enter_dr_shift();
    shift_bits(64'b101, 3, q);
    update_to_rti();
    check("bypass_0111_tdo", q[31:0], 32'b010);

    // Reset mid-shift
    load_ir(4'b0010);
    enter_dr_shift();
    shift_bits(64'hA5, 8, q);
    update_to_rti();
    check("dr_a5", 32'(DR), 32'hA5);
    enter_dr_shift();
    for (int i = 0; i < 3; i++) step(0, i[0], 0);
    step(0, 1, 1);
    check("midrst_state", 32'(STATE), 32'hF);
    check("midrst_dr", 32'(DR), 32'h0);
    check("midrst_ir", 32'(IR), 32'h1);

    // Randomized traffic, occasionally steering IR to USER so DR sees activity
    for (int i = 0; i < 1500; i++) begin
      if (m_state == 4'hC && $urandom_range(0, 19) == 0) load_ir(4'b0010);
      step($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 199) == 0);
    end

    @(negedge TCK);
    @(negedge TCK);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
